// File: rtl/video_stream_retimer_pkg.sv
// Shared definitions for the video stream retimer: FSM state encoding and
// the timing-segment helper used to derive line/frame totals.
package video_stream_retimer_pkg;

    typedef enum logic [1:0] {
        RESYNC    = 2'd0,
        WAIT_FILL = 2'd1,
        RUN       = 2'd2
    } state_t;

    function automatic logic [15:0] seg_total(
        input logic [15:0] sync_len,
        input logic [15:0] back_len,
        input logic [15:0] disp_len,
        input logic [15:0] front_len
    );
        return sync_len + back_len + disp_len + front_len;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO on an inferred RAM with registered read; a
// bypass register covers the cycle where the word being prefetched is written.
module sync_fifo_fwft #(
    parameter int WIDTH = 25,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] ram_rd_q;
    logic [WIDTH-1:0] byp_q, byp_d;
    logic             byp_sel_q, byp_sel_d;
    logic             do_rd, do_wr;

    assign empty = (level_q == '0);
    assign full  = level_q[AW];
    assign level = level_q;
    assign dout  = byp_sel_q ? byp_q : ram_rd_q;

    always_comb begin
        do_rd     = rd_en && !empty;
        // A write into a full FIFO is accepted only when a read frees a slot.
        do_wr     = wr_en && (!full || do_rd);
        rd_ptr_d  = rd_ptr_q + AW'(do_rd);
        wr_ptr_d  = wr_ptr_q + AW'(do_wr);
        level_d   = level_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        byp_sel_d = do_wr && (wr_ptr_q == rd_ptr_d);
        byp_d     = din;
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= din;
        end
        ram_rd_q <= mem[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            byp_q     <= '0;
            byp_sel_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            byp_q     <= byp_d;
            byp_sel_q <= byp_sel_d;
        end
    end

endmodule

// File: rtl/video_stream_retimer.sv
// Re-times a valid-qualified pixel stream onto hs/vs/de/rgb video timing,
// placing the image top-left and padding the rest of the display with BG_COLOR.
module video_stream_retimer
    import video_stream_retimer_pkg::*;
#(
    parameter logic [15:0] H_SYNC     = 16'd41,
    parameter logic [15:0] H_BACK     = 16'd2,
    parameter logic [15:0] H_DISP     = 16'd480,
    parameter logic [15:0] H_FRONT    = 16'd2,
    parameter logic [15:0] V_SYNC     = 16'd10,
    parameter logic [15:0] V_BACK     = 16'd2,
    parameter logic [15:0] V_DISP     = 16'd272,
    parameter logic [15:0] V_FRONT    = 16'd2,
    parameter logic        HS_POL     = 1'b1,
    parameter logic        VS_POL     = 1'b1,
    parameter int          DATA_WIDTH = 8,
    parameter int          CHANNELS   = 3,
    parameter int          FIFO_AW    = 11,
    parameter logic [DATA_WIDTH*CHANNELS-1:0] BG_COLOR = 24'h000000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH*CHANNELS-1:0] din,
    input  logic                           din_valid,
    input  logic                           din_sof,
    input  logic [15:0]                    act_w,
    input  logic [15:0]                    act_h,
    input  logic                           clr_err,
    output logic                           hs,
    output logic                           vs,
    output logic                           de,
    output logic [DATA_WIDTH*CHANNELS-1:0] rgb,
    output logic                           underflow,
    output logic                           overflow,
    output logic                           locked
);

    localparam int PW = DATA_WIDTH * CHANNELS;
    localparam logic [15:0] H_TOTAL  = seg_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam logic [15:0] V_TOTAL  = seg_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
    localparam logic [15:0] H_DSTART = H_SYNC + H_BACK;
    localparam logic [15:0] H_DEND   = H_DSTART + H_DISP;
    localparam logic [15:0] V_DSTART = V_SYNC + V_BACK;
    localparam logic [15:0] V_DEND   = V_DSTART + V_DISP;

    logic [15:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [15:0]    act_w_l_q, act_w_l_d, act_h_l_q, act_h_l_d;
    state_t         state_q, state_d;
    logic           hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [PW-1:0]  rgb_q, rgb_d;
    logic           underflow_q, underflow_d, overflow_q, overflow_d;
    logic           locked_q, locked_d;

    logic           frame_start, de_c, in_img;
    logic [15:0]    x_pos, y_pos;
    logic           fifo_wr, fifo_rd, fifo_empty, fifo_full;
    logic [PW:0]    fifo_dout;
    logic [FIFO_AW:0] fifo_level;
    logic           head_sof, unf_evt, ovf_evt;

    sync_fifo_fwft #(
        .WIDTH (PW + 1),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (fifo_wr),
        .din   ({din_sof, din}),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign head_sof = fifo_dout[PW];
    assign fifo_wr  = din_valid && !fifo_full;
    assign ovf_evt  = din_valid && fifo_full;

    always_comb begin
        frame_start = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
        h_cnt_d     = (h_cnt_q == H_TOTAL - 16'd1) ? 16'd0 : h_cnt_q + 16'd1;
        v_cnt_d     = v_cnt_q;
        if (h_cnt_q == H_TOTAL - 16'd1) begin
            v_cnt_d = (v_cnt_q == V_TOTAL - 16'd1) ? 16'd0 : v_cnt_q + 16'd1;
        end
        de_c   = (h_cnt_q >= H_DSTART) && (h_cnt_q < H_DEND) &&
                 (v_cnt_q >= V_DSTART) && (v_cnt_q < V_DEND);
        x_pos  = h_cnt_q - H_DSTART;
        y_pos  = v_cnt_q - V_DSTART;
        in_img = de_c && (x_pos < act_w_l_q) && (y_pos < act_h_l_q);
        act_w_l_d = frame_start ? act_w : act_w_l_q;
        act_h_l_d = frame_start ? act_h : act_h_l_q;
    end

    always_comb begin
        state_d = state_q;
        fifo_rd = 1'b0;
        unf_evt = 1'b0;
        case (state_q)
            RESYNC: begin
                if (!fifo_empty) begin
                    if (head_sof) begin
                        state_d = WAIT_FILL;
                    end else begin
                        fifo_rd = 1'b1;
                    end
                end
            end
            // The threshold uses act_w directly: it is the value being latched this cycle.
            WAIT_FILL: begin
                if (frame_start && (32'(fifo_level) >= 32'(act_w))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (frame_start && (fifo_empty || !head_sof)) begin
                    unf_evt = 1'b1;
                    state_d = RESYNC;
                end
                if (in_img) begin
                    if (fifo_empty) begin
                        unf_evt = 1'b1;
                        state_d = RESYNC;
                    end else begin
                        fifo_rd = 1'b1;
                    end
                end
            end
            default: state_d = RESYNC;
        endcase
        if (ovf_evt) begin
            state_d = RESYNC;
        end
    end

    always_comb begin
        hs_d        = (h_cnt_q < H_SYNC) ? HS_POL : ~HS_POL;
        vs_d        = (v_cnt_q < V_SYNC) ? VS_POL : ~VS_POL;
        de_d        = de_c;
        rgb_d       = (in_img && (state_q == RUN) && !fifo_empty) ? fifo_dout[PW-1:0] : BG_COLOR;
        underflow_d = unf_evt || (underflow_q && !clr_err);
        overflow_d  = ovf_evt || (overflow_q && !clr_err);
        locked_d    = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= 16'd0;
            v_cnt_q     <= 16'd0;
            act_w_l_q   <= 16'd0;
            act_h_l_q   <= 16'd0;
            state_q     <= RESYNC;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            de_q        <= 1'b0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            act_w_l_q   <= act_w_l_d;
            act_h_l_q   <= act_h_l_d;
            state_q     <= state_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            locked_q    <= locked_d;
        end
    end

    assign hs        = hs_q;
    assign vs        = vs_q;
    assign de        = de_q;
    assign rgb       = rgb_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_video_stream_retimer.sv
// Scoreboard bench for video_stream_retimer on a reduced 14x9 timing raster
// with a 32-deep FIFO; expected display pixels are queued per frame.
module tb_video_stream_retimer;

    localparam int HT  = 14;
    localparam int VT  = 9;
    localparam int FR  = HT * VT;
    localparam int HD  = 8;
    localparam int VD  = 6;
    localparam logic [23:0] BG = 24'h123456;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_sof = 1'b0;
    logic [15:0] act_w = 16'd4;
    logic [15:0] act_h = 16'd3;
    logic        clr_err = 1'b0;
    logic        hs, vs, de, underflow, overflow, locked;
    logic [23:0] rgb;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic [23:0] exp_q[$];

    video_stream_retimer #(
        .H_SYNC(16'd2), .H_BACK(16'd2), .H_DISP(16'd8), .H_FRONT(16'd2),
        .V_SYNC(16'd1), .V_BACK(16'd1), .V_DISP(16'd6), .V_FRONT(16'd1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .DATA_WIDTH(8), .CHANNELS(3), .FIFO_AW(5),
        .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_sof(din_sof),
        .act_w(act_w), .act_h(act_h), .clr_err(clr_err),
        .hs(hs), .vs(vs), .de(de), .rgb(rgb),
        .underflow(underflow), .overflow(overflow), .locked(locked)
    );

    always #5 clk = ~clk;

    // cyc equals the DUT raster position (h + v*HT) between clock edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] pix(input int id, input int i);
        return {id[7:0], i[7:0], 8'hA5};
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_frame(input int id, input int w, input int h, input int avail);
        for (int y = 0; y < VD; y++) begin
            for (int x = 0; x < HD; x++) begin
                if (x < w && y < h && (y * w + x) < avail) exp_q.push_back(pix(id, y * w + x));
                else                                       exp_q.push_back(BG);
            end
        end
        $display("frame: image %0d %0dx%0d, %0d pixels expected", id, w, h, avail);
    endtask

    task automatic frame_begin(input int f, input int id, input int w, input int h, input int avail);
        wait_cyc(f * FR);
        chk("sb_drain", exp_q.size(), 0);
        push_frame(id, w, h, avail);
    endtask

    task automatic feed(input int id, input int n, input logic with_sof);
        for (int i = 0; i < n; i++) begin
            din       = pix(id, i);
            din_valid = 1'b1;
            din_sof   = with_sof && (i == 0);
            @(negedge clk);
        end
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    // Pixel monitor: every de pixel pops one expectation; blanking must be BG.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && cyc > 0) begin
                if (de) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rgb_extra: got %0h, expected no de pixel (cyc %0d)", rgb, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rgb_pixel", rgb, e);
                    end
                end else begin
                    chk("rgb_blank", rgb, BG);
                end
            end
        end
    end

    // Timing monitor: hs/vs periods, de run length and de lines per frame.
    initial begin
        int   hs_last, vs_last, de_len, de_runs;
        logic hs_p, vs_p, de_p;
        hs_last = -1; vs_last = -1; de_len = 0; de_runs = 0;
        hs_p = 1'b0; vs_p = 1'b0; de_p = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || cyc == 0) begin
                hs_last = -1; vs_last = -1; de_len = 0; de_runs = 0;
                hs_p = 1'b0; vs_p = 1'b0; de_p = 1'b0;
            end else begin
                if (hs && !hs_p) begin
                    if (hs_last >= 0) chk("hs_period", cyc - hs_last, HT);
                    hs_last = cyc;
                end
                if (vs && !vs_p) begin
                    if (vs_last >= 0) begin
                        chk("vs_period", cyc - vs_last, FR);
                        chk("de_lines", de_runs, VD);
                    end
                    vs_last = cyc;
                    de_runs = 0;
                end
                if (de) begin
                    de_len++;
                end else if (de_p) begin
                    chk("de_len", de_len, HD);
                    de_runs++;
                    de_len = 0;
                end
                hs_p = hs; vs_p = vs; de_p = de;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_hs", hs, 0);
        chk("rst_vs", vs, 0);
        chk("rst_de", de, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_locked", locked, 0);
        frame_begin(0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("first_hs", hs, 1);
        chk("first_vs", vs, 1);

        // Idle frames, then the first image arrives late in frame 2.
        frame_begin(1, 0, 0, 0, 0);
        frame_begin(2, 0, 0, 0, 0);
        wait_cyc(2 * FR + 80);
        feed(1, 12, 1'b1);
        wait_cyc(2 * FR + 100);
        chk("wait_fill_unlocked", locked, 0);

        frame_begin(3, 1, 4, 3, 12);
        chk("lock_before_start", locked, 0);
        wait_cyc(3 * FR + 1);
        chk("lock_at_start", locked, 1);
        wait_cyc(3 * FR + 80);
        feed(2, 12, 1'b1);
        frame_begin(4, 2, 4, 3, 12);
        wait_cyc(4 * FR + 80);
        feed(3, 12, 1'b1);

        // Half an image: starve mid-line 1 of frame 6.
        frame_begin(5, 3, 4, 3, 12);
        wait_cyc(5 * FR + 80);
        feed(4, 6, 1'b1);
        frame_begin(6, 4, 4, 3, 6);
        wait_cyc(6 * FR + 48);
        chk("underflow_before", underflow, 0);
        wait_cyc(6 * FR + 49);
        chk("underflow_set", underflow, 1);
        chk("underflow_unlock", locked, 0);
        wait_cyc(6 * FR + 80);
        feed(5, 12, 1'b1);

        frame_begin(7, 5, 4, 3, 12);
        wait_cyc(7 * FR + 1);
        chk("relock", locked, 1);
        wait_cyc(7 * FR + 20);
        chk("underflow_sticky", underflow, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("underflow_cleared", underflow, 0);
        wait_cyc(7 * FR + 50);
        act_w = 16'd8;
        wait_cyc(7 * FR + 80);
        feed(6, 24, 1'b1);

        // Full-width frame, then a 33-word burst without sof into a 32-deep FIFO.
        frame_begin(8, 6, 8, 3, 24);
        wait_cyc(8 * FR + 80);
        feed(7, 32, 1'b0);
        chk("overflow_at_full", overflow, 0);
        din       = pix(7, 32);
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        chk("overflow_set", overflow, 1);
        chk("overflow_unlock", locked, 0);

        frame_begin(9, 0, 0, 0, 0);
        wait_cyc(9 * FR + 30);
        chk("overflow_sticky", overflow, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("overflow_cleared", overflow, 0);
        wait_cyc(9 * FR + 80);
        feed(8, 24, 1'b1);

        // Asynchronous reset in the middle of the first displayed line.
        frame_begin(10, 8, 8, 3, 24);
        wait_cyc(10 * FR + 1);
        chk("relock_after_overflow", locked, 1);
        wait_cyc(10 * FR + 36);
        chk("pre_reset_de", de, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_de", de, 0);
        chk("async_rst_rgb", rgb, 0);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_hs", hs, 0);
        chk("async_rst_vs", vs, 0);
        exp_q.delete();
        push_frame(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("restart_hs", hs, 1);
        chk("restart_vs", vs, 1);
        wait_cyc(32);
        chk("restart_de_off", de, 0);
        wait_cyc(33);
        chk("restart_de_on", de, 1);
        wait_cyc(FR + 5);
        chk("sb_final", exp_q.size(), 0);
        chk("restart_unlocked", locked, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
